count_ones_seq: RTL and testbench



---
 rtl/count_ones_seq.sv | 108 ++++++++++
 tb/tb_count_ones_seq.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/count_ones_seq.sv
// Sequential ones/zeros counter: scans a latched word bits_per_cycle bits per clock
// and stops early once no set bits remain in the shift register.
module count_ones_seq #(
  parameter int data_width     = 16,
  parameter int bits_per_cycle = 4,
  parameter int count_width    = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [data_width-1:0]  data,
  input  logic                   count_zeros,
  output logic                   ready,
  output logic                   done,
  output logic [count_width-1:0] bit_count,
  output logic                   dbg_state
);

  // Reject parameter sets the datapath cannot honour before anything runs.
  generate
    if ((bits_per_cycle < 1) || (bits_per_cycle > data_width) ||
        ((data_width % bits_per_cycle) != 0) ||
        ((64'd1 << count_width) <= 64'(data_width))) begin : g_param_err
      $fatal(1, "count_ones_seq: illegal parameters data_width=%0d bits_per_cycle=%0d count_width=%0d",
             data_width, bits_per_cycle, count_width);
    end
  endgenerate

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [data_width-1:0]  r_shreg;
  logic [data_width-1:0]  w_shreg_next;
  logic [data_width-1:0]  w_shifted;
  logic [count_width-1:0] r_acc;
  logic [count_width-1:0] w_acc_next;
  logic [count_width-1:0] w_acc_sum;
  logic [count_width-1:0] w_slice_pop;
  logic [count_width-1:0] r_bit_count;
  logic [count_width-1:0] w_bit_count_next;
  logic                   r_done;
  logic                   w_done_next;

  // Popcount of the low slice, each bit zero-extended to the accumulator width.
  always_comb begin
    w_slice_pop = '0;
    for (int i = 0; i < bits_per_cycle; i++) begin
      w_slice_pop = w_slice_pop + count_width'(r_shreg[i]);
    end
  end

  assign w_acc_sum = r_acc + w_slice_pop;
  assign w_shifted = r_shreg >> bits_per_cycle;

  always_comb begin
    w_state_next     = r_state;
    w_shreg_next     = r_shreg;
    w_acc_next       = r_acc;
    w_bit_count_next = r_bit_count;
    w_done_next      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_shreg_next = count_zeros ? ~data : data;
          w_acc_next   = '0;
          w_state_next = ST_COUNT;
        end
      end
      ST_COUNT: begin
        w_shreg_next = w_shifted;
        w_acc_next   = w_acc_sum;
        // Nothing left to count once the remaining bits are all zero.
        if (w_shifted == '0) begin
          w_bit_count_next = w_acc_sum;
          w_done_next      = 1'b1;
          w_state_next     = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_shreg     <= '0;
      r_acc       <= '0;
      r_bit_count <= '0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_shreg     <= w_shreg_next;
      r_acc       <= w_acc_next;
      r_bit_count <= w_bit_count_next;
      r_done      <= w_done_next;
    end
  end

  assign ready     = (r_state == ST_IDLE);
  assign done      = r_done;
  assign bit_count = r_bit_count;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_count_ones_seq.sv
// Bench for count_ones_seq: scenario tasks drive transactions, a done monitor pops
// expected counts and completion cycles from scoreboard queues.
module tb_count_ones_seq;

  localparam int DW = 16;
  localparam int BPC = 4;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [DW-1:0] data = '0;
  logic          count_zeros = 1'b0;
  logic          ready;
  logic          done;
  logic [CW-1:0] bit_count;
  logic          dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic prev_done = 1'b0;

  logic [CW-1:0] exp_q[$];
  int            exp_cyc_q[$];

  count_ones_seq #(.data_width(DW), .bits_per_cycle(BPC), .count_width(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .data(data), .count_zeros(count_zeros),
    .ready(ready), .done(done), .bit_count(bit_count), .dbg_state(dbg_state)
  );

  // Clock and edge counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic int model_lat(input logic [DW-1:0] w);
    int h = -1;
    int lat;
    for (int i = 0; i < DW; i++) if (w[i]) h = i;
    lat = (h + 1 + BPC - 1) / BPC;
    if (lat < 1) lat = 1;
    return lat;
  endfunction

  function automatic logic [CW-1:0] model_count(input logic [DW-1:0] w);
    logic [CW-1:0] c = '0;
    for (int i = 0; i < DW; i++) c = c + CW'(w[i]);
    return c;
  endfunction

  // Done monitor / scoreboard
  always @(negedge clk) begin
    if (!reset && done) begin
      checks++;
      if (prev_done) begin
        errors++;
        $display("FAIL done_width: done high two cycles in a row at cycle %0d", cyc);
      end
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL spurious_done: done at cycle %0d with no transaction outstanding", cyc);
      end else begin
        logic [CW-1:0] e;
        int ec;
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        checks++;
        if (bit_count !== e) begin
          errors++;
          $display("FAIL bit_count: got %0d expected %0d", bit_count, e);
        end
        checks++;
        if (cyc !== ec) begin
          errors++;
          $display("FAIL done_latency: done at cycle %0d expected cycle %0d", cyc, ec);
        end
        checks++;
        if (ready !== 1'b1) begin
          errors++;
          $display("FAIL ready_with_done: got %b expected 1", ready);
        end
      end
    end
    prev_done = done;
  end

  // Drivers: drive_now assumes the caller sits at a negedge with ready high.
  task automatic drive_now(input logic [DW-1:0] w, input logic cz);
    logic [DW-1:0] lw;
    lw = cz ? ~w : w;
    start = 1'b1;
    data = w;
    count_zeros = cz;
    exp_q.push_back(model_count(lw));
    exp_cyc_q.push_back(cyc + 1 + model_lat(lw));
    @(posedge clk);
    #1;
    start = 1'b0;
    data = DW'($urandom);
    count_zeros = 1'($urandom);
  endtask

  task automatic drive_start(input logic [DW-1:0] w, input logic cz);
    int n = 0;
    @(negedge clk);
    while (!ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      checks++;
      errors++;
      $display("FAIL drive_ready_timeout: ready %b expected 1", ready);
    end else begin
      drive_now(w, cz);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding expected 0", exp_q.size());
      exp_q.delete();
      exp_cyc_q.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++;
    if (bit_count !== '0) begin errors++; $display("FAIL reset_bit_count: got %0d expected 0", bit_count); end
    checks++;
    if (dbg_state !== 1'b0) begin errors++; $display("FAIL reset_state: got %b expected 0", dbg_state); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL idle_done: got %b expected 0", done); end
    end
  endtask

  task automatic test_full_word();
    drive_start(16'hFFFF, 1'b0);
    @(negedge clk);
    checks++;
    if (ready !== 1'b0 || dbg_state !== 1'b1) begin
      errors++;
      $display("FAIL busy_flags: ready %b state %b expected 0/1", ready, dbg_state);
    end
    wait_drain();
  endtask

  task automatic test_early_exit();
    drive_start(16'h000A, 1'b0);
    wait_drain();
    drive_start(16'h0000, 1'b0);
    wait_drain();
  endtask

  task automatic test_zeros_mode();
    drive_start(16'hFFF0, 1'b1);
    wait_drain();
    drive_start(16'h0B00, 1'b0);
    wait_drain();
  endtask

  task automatic test_ignore_start();
    drive_start(16'h8001, 1'b0);
    @(negedge clk);
    start = 1'b1;
    data = 16'h0000;
    count_zeros = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_drain();
  endtask

  task automatic test_back_to_back();
    int n = 0;
    drive_start(16'h0003, 1'b0);
    @(negedge clk);
    while (!done && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_done_timeout: done %b expected 1", done);
    end else begin
      drive_now(16'h00C0, 1'b0);
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || bit_count !== 5'd2 || ready !== 1'b0) begin
        errors++;
        $display("FAIL b2b_hold: done %b bit_count %0d ready %b expected 0/2/0", done, bit_count, ready);
      end
    end
    wait_drain();
  endtask

  task automatic test_reset_mid();
    drive_start(16'hFFFF, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    exp_q.delete();
    exp_cyc_q.delete();
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || done !== 1'b0 || bit_count !== '0 || dbg_state !== 1'b0) begin
      errors++;
      $display("FAIL abort_state: ready %b done %b bit_count %0d state %b expected 1/0/0/0",
               ready, done, bit_count, dbg_state);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b expected 0", done); end
    end
    drive_start(16'h0003, 1'b0);
    wait_drain();
  endtask

  task automatic test_random();
    for (int t = 0; t < 12; t++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      drive_start(DW'($urandom) >> $urandom_range(0, 15), 1'($urandom_range(0, 1)));
    end
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_early_exit();
    test_zeros_mode();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_random();
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
